// File: rtl/ser_pkg.sv
// Shared types and index helpers for the
// bit serializer controller and its mux.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int sel_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int start_idx(
    input int n,
    input bit msb_first
  );
    return msb_first ? n - 1 : 0;
  endfunction

  function automatic int end_idx(
    input int n,
    input bit msb_first
  );
    return msb_first ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// N-to-1 bit mux; out-of-range select
// yields 0 so non power-of-two N is safe.
module mux_n_to_1
  import ser_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  data_i,
  input  logic [SW-1:0] sel_i,
  output logic          out_o
);

  // pick the addressed input bit
  always_comb begin
    out_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SW'(i)) begin
        out_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/mux_serializer_ctrl.sv
// Parallel-in / serial-out controller that
// walks the mux select across a held word.
module mux_serializer_ctrl
  import ser_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int SEL_W     = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     load_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] START_IDX =
    SEL_W'(start_idx(N, MSB_FIRST));
  localparam logic [SEL_W-1:0] STOP_IDX =
    SEL_W'(end_idx(N, MSB_FIRST));

  state_e           state_q;
  state_e           state_d;
  logic [N-1:0]     word_q;
  logic [N-1:0]     word_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             at_end;
  logic             load;

  assign at_end = (sel_q == STOP_IDX);

  // next state, handshakes and select stepping
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    sel_d      = sel_q;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    load_ready = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        load       = load_valid;
        if (load) begin
          word_d  = load_data;
          sel_d   = START_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_last   = at_end;
        load_ready = at_end & ser_ready;
        load       = load_valid & load_ready;
        if (ser_ready) begin
          if (at_end) begin
            // rewind so IDLE and a chained
            // word both start at the origin
            sel_d = START_IDX;
            if (load) begin
              word_d = load_data;
            end else begin
              state_d = IDLE;
            end
          end else if (MSB_FIRST) begin
            sel_d = sel_q - SEL_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
    endcase
  end

  // state, word and select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= START_IDX;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  mux_n_to_1 #(
    .N  (N),
    .SW (SEL_W)
  ) u_mux (
    .data_i (word_q),
    .sel_i  (sel_q),
    .out_o  (ser_out)
  );

  assign sel  = sel_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// Scoreboard bench: three configurations
// (N=8 LSB, N=8 MSB, N=1) run side by side.
module tb_mux_serializer_ctrl;

  typedef struct {
    bit b;
    bit last;
    int idx;
  } beat_t;

  logic clk;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input int          c,
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s got %0d exp %0d",
               c, nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int GN = (g == 2) ? 1 : 8;
    localparam bit GM = (g == 1);
    localparam int GS = (GN > 1) ? $clog2(GN) : 1;
    localparam int START = GM ? GN - 1 : 0;

    logic          rst;
    logic          lv;
    logic          lr;
    logic [GN-1:0] ld;
    logic          sr;
    logic          sv;
    logic          so;
    logic          sl;
    logic [GS-1:0] sel_o;
    logic          bz;
    bit            mon_en;
    bit            done;
    beat_t         expq[$];
    beat_t         e_m;

    mux_serializer_ctrl #(
      .N         (GN),
      .MSB_FIRST (GM)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (lv),
      .load_ready (lr),
      .load_data  (ld),
      .ser_ready  (sr),
      .ser_valid  (sv),
      .ser_out    (so),
      .ser_last   (sl),
      .sel        (sel_o),
      .busy       (bz)
    );

    // expected bit order of one accepted word
    function automatic void push_word(
      input logic [GN-1:0] w
    );
      int idx;
      for (int k = 0; k < GN; k++) begin
        idx = GM ? GN - 1 - k : k;
        expq.push_back('{w[idx], k == GN - 1, idx});
      end
    endfunction

    // one clock of stimulus; reports load/last
    task automatic step(
      input  bit            v,
      input  logic [GN-1:0] d,
      input  bit            r,
      input  bit            rs,
      output bit            f,
      output bit            l
    );
      lv  = v;
      ld  = d;
      sr  = r;
      rst = rs;
      @(negedge clk);
      f = v && lr && !rs;
      l = sv && r && sl && !rs;
      @(posedge clk);
      #1;
      if (rs) expq.delete();
      else if (f) push_word(d);
    endtask

    always @(negedge clk) begin
      if (mon_en && !rst) begin
        if (expq.size() == 0) begin
          chk(g, "idle_valid", sv, 0);
          chk(g, "idle_last", sl, 0);
          chk(g, "idle_ready", lr, 1);
          chk(g, "idle_busy", bz, 0);
        end else begin
          e_m = expq[0];
          chk(g, "valid", sv, 1);
          chk(g, "bit", so, e_m.b);
          chk(g, "last", sl, e_m.last);
          chk(g, "sel", sel_o, e_m.idx);
          chk(g, "busy", bz, 1);
          chk(g, "load_ready", lr,
              e_m.last && sr);
          if (sr) void'(expq.pop_front());
        end
      end
    end

    initial begin
      bit          f;
      bit          l;
      int          c;
      int          i;
      int          nw;
      int          lasts;
      logic [7:0]  bw[3];
      logic [7:0]  w0;
      logic [31:0] rnd;
      bit          rv;
      bit          rr;
      bit          rrs;
      mon_en = 0;
      done   = 0;
      rst = 1;
      lv  = 0;
      sr  = 0;
      ld  = '0;
      step(0, '0, 0, 1, f, l);
      step(0, '0, 0, 1, f, l);
      chk(g, "rst_load_ready", lr, 1);
      chk(g, "rst_valid", sv, 0);
      chk(g, "rst_last", sl, 0);
      chk(g, "rst_busy", bz, 0);
      chk(g, "rst_sel", sel_o, START);
      mon_en = 1;

      w0 = GM ? 8'hA5 : 8'hB3;
      if (GN == 1) w0 = 8'h01;
      step(1, w0[GN-1:0], 1, 0, f, l);
      chk(g, "first_load", f, 1);
      c = 0;
      do begin
        c++;
        step(0, '0, 1, 0, f, l);
      end while (!l && c < 4 * GN + 8);
      chk(g, "cycles_to_last", c, GN);

      step(1, 8'h6C, 1, 0, f, l);
      chk(g, "bp_load", f, 1);
      c = 0;
      do begin
        c++;
        step(0, '0, !(c >= 3 && c <= 5), 0, f, l);
      end while (!l && c < 4 * GN + 8);
      chk(g, "bp_cycles", c, GN + ((GN > 2) ? 3 : 0));

      if (GN == 1) begin
        bw[0] = 8'h01;
        bw[1] = 8'h00;
        bw[2] = 8'h01;
        nw    = 3;
      end else begin
        bw[0] = 8'hFF;
        bw[1] = 8'h00;
        bw[2] = 8'h00;
        nw    = 2;
      end
      step(1, bw[0][GN-1:0], 1, 0, f, l);
      i = 1;
      c = 0;
      lasts = 0;
      while (lasts < nw && c < 8 * GN + 8) begin
        c++;
        step(i < nw,
             (i < nw) ? bw[i][GN-1:0] : '0,
             1, 0, f, l);
        if (f) i++;
        if (l) lasts++;
      end
      chk(g, "b2b_words", i, nw);
      chk(g, "b2b_lasts", lasts, nw);
      chk(g, "b2b_cycles", c, nw * GN);

      step(1, 8'h5A, 1, 0, f, l);
      lasts = 0;
      for (int k = 0; k < 4; k++) begin
        step(0, '0, 1, 0, f, l);
        if (l) lasts++;
      end
      chk(g, "abort_lasts", lasts,
          (GN <= 4) ? 1 : 0);
      step(0, '0, 1, 1, f, l);
      chk(g, "abort_valid", sv, 0);
      chk(g, "abort_last", sl, 0);
      chk(g, "abort_busy", bz, 0);
      chk(g, "abort_sel", sel_o, START);

      for (int k = 0; k < 400; k++) begin
        rv  = $urandom_range(0, 1) == 1;
        rnd = $urandom;
        rr  = $urandom_range(0, 9) < 7;
        rrs = $urandom_range(0, 79) == 0;
        step(rv, rnd[GN-1:0], rr, rrs, f, l);
      end

      c = 0;
      while (expq.size() > 0 && c < 4 * GN + 8) begin
        c++;
        step(0, '0, 1, 0, f, l);
      end
      chk(g, "drained", expq.size(), 0);
      step(0, '0, 1, 0, f, l);
      done = 1;
    end
  end

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done &&
             g_cfg[2].done) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL timeout got %0d exp <20000",
               cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
